chess_drill_core: RTL and testbench
===================================

CHESS_DRILL_CORE -- requirements
Module: chess_drill_core

Interface
REQ-001 The module SHALL have these parameters:
- N_PLAYERS, 2: players taking turns, 1..4.
- COORD_W, 3: row/column width, so the board is 2^COORD_W square.
- SCORE_W, 8: per-player score width.
- TIME_W, 8: round-timer width.
- TIME_INIT, 30: timer load value in ticks, 1..2^TIME_W-1.
- PENALTY, 5: ticks deducted on a wrong move.
- MAX_ROUNDS, 8: rounds per game across all players.
- HOLD_CYCLES, 50000000: cycles that acertou/errou stay high.
- SEED, 16'hACE1: LFSR seed, nonzero.

REQ-002 The module SHALL have these ports:
- clock, in, 1: rising-edge clock.
- reset, in, 1: one clock; reset is synchronous and active-low.
- iniciar, in, 1: start a game.
- terminar, in, 1: abort to end of game.
- tick, in, 1: one-cycle timebase strobe.
- temJogada, in, 1: one-cycle move-valid pulse.
- jogadaJogador, in, clog2(N_PLAYERS): player who made the move.
- jogadaFileira, in, COORD_W: row of the move.
- jogadaColuna, in, COORD_W: column of the move.
- linhaEsperada, out, COORD_W: target row.
- colunaEsperada, out, COORD_W: target column.
- pontos, out, N_PLAYERS*SCORE_W: scores; player p occupies bits [p*SCORE_W +: SCORE_W].
- vez, out, clog2(N_PLAYERS): current player.
- tempo, out, TIME_W: remaining ticks.
- acertou, out, 1: held correct-move flag.
- errou, out, 1: held wrong-move or timeout flag.
- fim, out, 1: game over.
- db_estado, out, 4: state code.

Function
REQ-003 The FSM states SHALL be IDLE=0, PREPARA=1, ESPERA=2, AVALIA=3, PROXIMA=4, FIM=5, and db_estado SHALL show the current code.

REQ-004 When iniciar is high in IDLE or FIM, the next state SHALL be PREPARA, and all scores, the round count and vez SHALL clear to 0.

REQ-005 PREPARA SHALL last one cycle and SHALL:
- latch the target from the LFSR: row = lfsr[COORD_W-1:0], column = lfsr[2*COORD_W-1:COORD_W];
- load tempo with TIME_INIT;
- go to ESPERA.

REQ-006 In ESPERA, a temJogada pulse with jogadaJogador==vez SHALL register the move, and the next state SHALL be AVALIA. A temJogada pulse from any other player SHALL be ignored.

REQ-007 In AVALIA, a move whose row and column both match the target SHALL:
- increment pontos[vez], saturating at 2^SCORE_W-1;
- start the acertou hold;
- go to PROXIMA.

REQ-008 In AVALIA, a mismatched move SHALL start the errou hold and return to ESPERA with the same target.

REQ-009 In ESPERA, tick SHALL decrement tempo. When tempo reaches 0, the FSM SHALL start the errou hold and go to PROXIMA with no point awarded.

REQ-010 If temJogada and tick occur in the same ESPERA cycle, the move SHALL take precedence and tempo SHALL NOT decrement that cycle.

REQ-011 PROXIMA SHALL:
- increment the round count;
- advance vez modulo N_PLAYERS, so it wraps from N_PLAYERS-1 to 0;
- go to FIM when the round count reaches MAX_ROUNDS, otherwise to PREPARA.

REQ-012 terminar SHALL force FIM from any state except IDLE, with priority over all events except reset. Scores SHALL be retained.

REQ-013 fim SHALL be high exactly while the state is FIM. temJogada and tick SHALL be ignored outside ESPERA.

REQ-014 acertou and errou SHALL each rise the cycle after their triggering event and stay high for HOLD_CYCLES cycles. A new event SHALL restart the hold, and starting one flag SHALL clear the other.

REQ-015 The LFSR SHALL advance every cycle in every state, so the target depends on the start time.

Reset
REQ-016 While reset is low at a clock edge, the outputs SHALL clear as follows:
- state SHALL be IDLE;
- pontos, vez, tempo, the targets, acertou, errou and fim SHALL be 0;
- the hold counters SHALL be 0;
- the LFSR SHALL be SEED.

REQ-017 Reset mid-game SHALL discard the game completely, with no partial score kept.

Configuration
REQ-018 With CHESS_PENALTY_EN defined, a wrong move SHALL reduce tempo by PENALTY, saturating at 0. A result of 0 SHALL take the timeout path of REQ-009 on the next cycle.

REQ-019 Without CHESS_PENALTY_EN, a wrong move SHALL leave tempo unchanged.

Structure
REQ-020 The package chess_pkg SHALL hold:
- the state enum and its codes;
- the LFSR taps (x^16+x^14+x^13+x^11+1).

REQ-021 The sub-module chess_target_lfsr SHALL contain the 16-bit Fibonacci LFSR and SHALL have ports clock, reset and lfsr[15:0].

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Reset then iniciar, P0 answers the target correctly: pontos[0]=1, acertou high for HOLD_CYCLES (set to 4 in the bench), vez=1.
- Wrong move with TIME_INIT=30, PENALTY=5 and the macro on: tempo=25, errou high, state returns to ESPERA. With the macro off: tempo=30.
- No move for 30 ticks: errou set, pontos unchanged, state goes to PROXIMA, then PREPARA with vez advanced.
- temJogada from P1 during P0's turn: ignored, state stays ESPERA. temJogada and tick in the same cycle: tempo does not decrement.
- MAX_ROUNDS=8 with all moves correct and N_PLAYERS=2: fim=1, each player has pontos=4, vez wraps to 0.
- terminar during ESPERA: FIM the next cycle, scores held. Reset low during AVALIA: all outputs 0 the next cycle.

Source files
------------

// File: rtl/chess_pkg.sv
// Shared types for the chess drill core: FSM state codes and the target LFSR polynomial.
package chess_pkg;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_PREPARA = 4'd1,
        ST_ESPERA  = 4'd2,
        ST_AVALIA  = 4'd3,
        ST_PROXIMA = 4'd4,
        ST_FIM     = 4'd5
    } state_t;

    // x^16 + x^14 + x^13 + x^11 + 1, feedback from bits 15, 13, 12, 10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/chess_target_lfsr.sv
// Free-running 16-bit Fibonacci LFSR that supplies pseudo-random drill targets.
module chess_target_lfsr
    import chess_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clock,
    input  logic        reset,
    output logic [15:0] lfsr
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr = lfsr_q;

endmodule

// File: rtl/chess_drill_core.sv
// Timed board-square drill: players take turns hitting an LFSR-chosen target square.
// Build option: define CHESS_PENALTY_EN to deduct PENALTY ticks on each wrong move.
//
// state   | meaning
// IDLE    | waiting for iniciar after reset
// PREPARA | latch new target, reload round timer
// ESPERA  | waiting for the current player's move, timer running
// AVALIA  | compare registered move against target
// PROXIMA | close round, rotate player, decide game over
// FIM     | game over, scores held until iniciar
module chess_drill_core
    import chess_pkg::*;
#(
    parameter int          N_PLAYERS   = 2,
    parameter int          COORD_W     = 3,
    parameter int          SCORE_W     = 8,
    parameter int          TIME_W      = 8,
    parameter int          TIME_INIT   = 30,
    parameter int          PENALTY     = 5,
    parameter int          MAX_ROUNDS  = 8,
    parameter int          HOLD_CYCLES = 50000000,
    parameter logic [15:0] SEED        = 16'hACE1,
    localparam int         VEZ_W       = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         iniciar,
    input  logic                         terminar,
    input  logic                         tick,
    input  logic                         temJogada,
    input  logic [VEZ_W-1:0]             jogadaJogador,
    input  logic [COORD_W-1:0]           jogadaFileira,
    input  logic [COORD_W-1:0]           jogadaColuna,
    output logic [COORD_W-1:0]           linhaEsperada,
    output logic [COORD_W-1:0]           colunaEsperada,
    output logic [N_PLAYERS*SCORE_W-1:0] pontos,
    output logic [VEZ_W-1:0]             vez,
    output logic [TIME_W-1:0]            tempo,
    output logic                         acertou,
    output logic                         errou,
    output logic                         fim,
    output logic [3:0]                   db_estado
);

    localparam int ROUND_W = $clog2(MAX_ROUNDS + 1);
    localparam int HOLD_W  = $clog2(HOLD_CYCLES + 1);

    localparam logic [ROUND_W-1:0] ROUND_MAX = ROUND_W'(MAX_ROUNDS);
    localparam logic [HOLD_W-1:0]  HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [TIME_W-1:0]  TIME_LOAD = TIME_W'(TIME_INIT);
    localparam logic [TIME_W-1:0]  PEN_TICKS = TIME_W'(PENALTY);
    localparam logic [VEZ_W-1:0]   VEZ_LAST  = VEZ_W'(N_PLAYERS - 1);
`ifdef CHESS_PENALTY_EN
    localparam bit PEN_EN = 1'b1;
`else
    localparam bit PEN_EN = 1'b0;
`endif

    state_t                         state_q;
    logic [N_PLAYERS*SCORE_W-1:0]   pontos_q;
    logic [VEZ_W-1:0]               vez_q;
    logic [ROUND_W-1:0]             round_q;
    logic [TIME_W-1:0]              tempo_q;
    logic [COORD_W-1:0]             alvo_lin_q, alvo_col_q;
    logic [COORD_W-1:0]             mov_lin_q, mov_col_q;
    logic                           acertou_q, errou_q;
    logic [HOLD_W-1:0]              hold_ac_q, hold_er_q;

    logic [15:0]                    lfsr_w;
    logic                           unused_lfsr;
    logic [SCORE_W-1:0]             score_cur_d, score_inc_d;
    logic [TIME_W-1:0]              tempo_wrong_d;
    logic [VEZ_W-1:0]               vez_nxt_d;
    logic [ROUND_W-1:0]             round_nxt_d;
    logic                           acerto_d;

    chess_target_lfsr #(.SEED(SEED)) u_lfsr (
        .clock (clock),
        .reset (reset),
        .lfsr  (lfsr_w)
    );

    // Only the low 2*COORD_W bits pick the target; the rest just keep the sequence long.
    assign unused_lfsr = ^lfsr_w;

    always_comb begin
        score_cur_d   = pontos_q[int'(vez_q)*SCORE_W +: SCORE_W];
        score_inc_d   = (&score_cur_d) ? score_cur_d : score_cur_d + 1'b1;
        tempo_wrong_d = tempo_q;
        if (PEN_EN) begin
            tempo_wrong_d = (tempo_q > PEN_TICKS) ? tempo_q - PEN_TICKS : '0;
        end
        vez_nxt_d     = (vez_q == VEZ_LAST) ? '0 : vez_q + 1'b1;
        round_nxt_d   = round_q + 1'b1;
        acerto_d      = (mov_lin_q == alvo_lin_q) && (mov_col_q == alvo_col_q);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            pontos_q   <= '0;
            vez_q      <= '0;
            round_q    <= '0;
            tempo_q    <= '0;
            alvo_lin_q <= '0;
            alvo_col_q <= '0;
            mov_lin_q  <= '0;
            mov_col_q  <= '0;
            acertou_q  <= 1'b0;
            errou_q    <= 1'b0;
            hold_ac_q  <= '0;
            hold_er_q  <= '0;
        end else begin
            // Hold timers count down; a flag drops the cycle after its counter hits zero.
            if (hold_ac_q != '0) hold_ac_q <= hold_ac_q - 1'b1;
            else                 acertou_q <= 1'b0;
            if (hold_er_q != '0) hold_er_q <= hold_er_q - 1'b1;
            else                 errou_q   <= 1'b0;

            if (terminar && (state_q != ST_IDLE)) begin
                state_q <= ST_FIM;
            end else begin
                case (state_q)
                    ST_IDLE, ST_FIM: begin
                        if (iniciar) begin
                            state_q  <= ST_PREPARA;
                            pontos_q <= '0;
                            round_q  <= '0;
                            vez_q    <= '0;
                        end
                    end
                    ST_PREPARA: begin
                        alvo_lin_q <= lfsr_w[COORD_W-1:0];
                        alvo_col_q <= lfsr_w[2*COORD_W-1:COORD_W];
                        tempo_q    <= TIME_LOAD;
                        state_q    <= ST_ESPERA;
                    end
                    ST_ESPERA: begin
                        if (tempo_q == '0) begin
                            errou_q   <= 1'b1;
                            hold_er_q <= HOLD_LOAD;
                            acertou_q <= 1'b0;
                            hold_ac_q <= '0;
                            state_q   <= ST_PROXIMA;
                        end else if (temJogada && (jogadaJogador == vez_q)) begin
                            mov_lin_q <= jogadaFileira;
                            mov_col_q <= jogadaColuna;
                            state_q   <= ST_AVALIA;
                        end else if (tick) begin
                            tempo_q <= tempo_q - 1'b1;
                        end
                    end
                    ST_AVALIA: begin
                        if (acerto_d) begin
                            pontos_q[int'(vez_q)*SCORE_W +: SCORE_W] <= score_inc_d;
                            acertou_q <= 1'b1;
                            hold_ac_q <= HOLD_LOAD;
                            errou_q   <= 1'b0;
                            hold_er_q <= '0;
                            state_q   <= ST_PROXIMA;
                        end else begin
                            errou_q   <= 1'b1;
                            hold_er_q <= HOLD_LOAD;
                            acertou_q <= 1'b0;
                            hold_ac_q <= '0;
                            tempo_q   <= tempo_wrong_d;
                            state_q   <= ST_ESPERA;
                        end
                    end
                    ST_PROXIMA: begin
                        round_q <= round_nxt_d;
                        vez_q   <= vez_nxt_d;
                        state_q <= (round_nxt_d == ROUND_MAX) ? ST_FIM : ST_PREPARA;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign linhaEsperada  = alvo_lin_q;
    assign colunaEsperada = alvo_col_q;
    assign pontos         = pontos_q;
    assign vez            = vez_q;
    assign tempo          = tempo_q;
    assign acertou        = acertou_q;
    assign errou          = errou_q;
    assign fim            = (state_q == ST_FIM);
    assign db_estado      = state_q;

endmodule

// File: tb/tb_chess_drill_core.sv
// Directed self-checking bench for chess_drill_core (table of full-game moves plus corner sequences).
module tb_chess_drill_core;

    localparam int          NP   = 2;
    localparam int          CW   = 3;
    localparam int          SW   = 8;
    localparam int          TW   = 8;
    localparam int          TI   = 30;
    localparam int          PEN  = 5;
    localparam int          MR   = 8;
    localparam int          HOLD = 4;
    localparam logic [15:0] SEED = 16'hACE1;
`ifdef CHESS_PENALTY_EN
    localparam int EXP_WRONG = TI - PEN;
`else
    localparam int EXP_WRONG = TI;
`endif

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic            iniciar = 1'b0, terminar = 1'b0, tick = 1'b0, temJogada = 1'b0;
    logic [0:0]      jogadaJogador = '0;
    logic [CW-1:0]   jogadaFileira = '0, jogadaColuna = '0;
    logic [CW-1:0]   linhaEsperada, colunaEsperada;
    logic [NP*SW-1:0] pontos;
    logic [0:0]      vez;
    logic [TW-1:0]   tempo;
    logic            acertou, errou, fim;
    logic [3:0]      db_estado;

    chess_drill_core #(
        .N_PLAYERS(NP), .COORD_W(CW), .SCORE_W(SW), .TIME_W(TW), .TIME_INIT(TI),
        .PENALTY(PEN), .MAX_ROUNDS(MR), .HOLD_CYCLES(HOLD), .SEED(SEED)
    ) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .terminar(terminar), .tick(tick),
        .temJogada(temJogada), .jogadaJogador(jogadaJogador), .jogadaFileira(jogadaFileira),
        .jogadaColuna(jogadaColuna), .linhaEsperada(linhaEsperada), .colunaEsperada(colunaEsperada),
        .pontos(pontos), .vez(vez), .tempo(tempo), .acertou(acertou), .errou(errou),
        .fim(fim), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    // Reference LFSR: x^16+x^14+x^13+x^11+1, shifting left, feedback into bit 0.
    logic [15:0] m_lfsr;
    always @(posedge clock) begin
        if (!reset) m_lfsr <= SEED;
        else        m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    typedef struct {
        logic [0:0] player;
        int         exp_p0;
        int         exp_p1;
        int         exp_vez;
        int         exp_state;
    } move_vec_t;

    move_vec_t   game2 [MR];
    int          n_pass = 0;
    int          n_total = 0;
    logic [CW-1:0] exp_row, exp_col;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic int pts(input int p);
        return int'(pontos[p*SW +: SW]);
    endfunction

    task automatic goto_espera();
        int n = 0;
        while (db_estado != 4'd1 && n < 20) begin
            step();
            n++;
        end
        check("reach_prepara", db_estado, 1);
        exp_row = m_lfsr[CW-1:0];
        exp_col = m_lfsr[2*CW-1:CW];
        step();
        check("enter_espera", db_estado, 2);
        check("target_row", linhaEsperada, exp_row);
        check("target_col", colunaEsperada, exp_col);
        check("tempo_load", tempo, TI);
    endtask

    task automatic do_move(input logic [0:0] player, input bit correct, input bit with_tick);
        temJogada     = 1'b1;
        jogadaJogador = player;
        jogadaFileira = correct ? exp_row : (exp_row ^ 3'd1);
        jogadaColuna  = exp_col;
        tick          = with_tick;
        step();
        temJogada = 1'b0;
        tick      = 1'b0;
    endtask

    initial begin
        game2[0] = '{1'b0, 1, 0, 1, 1};
        game2[1] = '{1'b1, 1, 1, 0, 1};
        game2[2] = '{1'b0, 2, 1, 1, 1};
        game2[3] = '{1'b1, 2, 2, 0, 1};
        game2[4] = '{1'b0, 3, 2, 1, 1};
        game2[5] = '{1'b1, 3, 3, 0, 1};
        game2[6] = '{1'b0, 4, 3, 1, 1};
        game2[7] = '{1'b1, 4, 4, 0, 5};

        reset = 1'b0;
        step();
        step();
        check("rst_state", db_estado, 0);
        check("rst_pontos", pontos, 0);
        check("rst_vez", vez, 0);
        check("rst_tempo", tempo, 0);
        check("rst_row", linhaEsperada, 0);
        check("rst_col", colunaEsperada, 0);
        check("rst_acertou", acertou, 0);
        check("rst_errou", errou, 0);
        check("rst_fim", fim, 0);
        reset = 1'b1;

        // Round 1: P0 hits the target, acertou held for HOLD cycles
        iniciar = 1'b1;
        step();
        iniciar = 1'b0;
        goto_espera();
        do_move(1'b0, 1'b1, 1'b0);
        check("s1_avalia", db_estado, 3);
        step();
        check("s1_proxima", db_estado, 4);
        check("s1_p0", pts(0), 1);
        check("s1_acertou", acertou, 1);
        check("s1_errou", errou, 0);
        step();
        check("s1_prepara", db_estado, 1);
        check("s1_vez", vez, 1);
        check("s1_hold2", acertou, 1);
        goto_espera();
        check("s1_hold3", acertou, 1);
        step();
        check("s1_hold4", acertou, 1);
        step();
        check("s1_hold_end", acertou, 0);

        // Round 2: P1 wrong move, then correct move together with tick
        do_move(1'b1, 1'b0, 1'b0);
        check("s2_avalia", db_estado, 3);
        step();
        check("s2_back_espera", db_estado, 2);
        check("s2_errou", errou, 1);
        check("s2_tempo_wrong", tempo, EXP_WRONG);
        check("s2_target_kept", linhaEsperada, exp_row);
        do_move(1'b1, 1'b1, 1'b1);
        check("s2_move_over_tick_state", db_estado, 3);
        check("s2_move_over_tick_tempo", tempo, EXP_WRONG);
        step();
        check("s2_proxima", db_estado, 4);
        check("s2_p1", pts(1), 1);
        check("s2_acertou", acertou, 1);
        check("s2_errou_cleared", errou, 0);
        step();
        check("s2_vez_wrap", vez, 0);

        // Round 3: wrong-player move ignored, then timeout after TI ticks
        goto_espera();
        do_move(1'b1, 1'b1, 1'b0);
        check("s3_wrong_player", db_estado, 2);
        step();
        check("s3_still_espera", db_estado, 2);
        check("s3_p0_kept", pts(0), 1);
        tick = 1'b1;
        for (int i = 0; i < TI; i++) step();
        tick = 1'b0;
        check("s3_tempo_zero", tempo, 0);
        check("s3_espera_at_zero", db_estado, 2);
        step();
        check("s3_timeout_proxima", db_estado, 4);
        check("s3_timeout_errou", errou, 1);
        check("s3_timeout_p0", pts(0), 1);
        check("s3_timeout_p1", pts(1), 1);
        step();
        check("s3_prepara", db_estado, 1);
        check("s3_vez", vez, 1);

        // Round 4: terminar aborts, scores retained, inputs ignored in FIM
        goto_espera();
        terminar = 1'b1;
        step();
        terminar = 1'b0;
        check("s4_fim_state", db_estado, 5);
        check("s4_fim", fim, 1);
        check("s4_p0", pts(0), 1);
        check("s4_p1", pts(1), 1);
        tick = 1'b1;
        temJogada = 1'b1;
        jogadaJogador = 1'b1;
        step();
        tick = 1'b0;
        temJogada = 1'b0;
        check("s4_fim_ignores", db_estado, 5);
        check("s4_tempo_frozen", tempo, TI);

        // Game 2: full game, all moves correct
        iniciar = 1'b1;
        step();
        iniciar = 1'b0;
        check("g2_prepara", db_estado, 1);
        check("g2_scores_clear", pontos, 0);
        check("g2_vez_clear", vez, 0);
        check("g2_fim_low", fim, 0);
        for (int i = 0; i < MR; i++) begin
            goto_espera();
            do_move(game2[i].player, 1'b1, 1'b0);
            step();
            check("g2_p0", pts(0), game2[i].exp_p0);
            check("g2_p1", pts(1), game2[i].exp_p1);
            check("g2_acertou", acertou, 1);
            step();
            check("g2_state", db_estado, game2[i].exp_state);
            check("g2_vez", vez, game2[i].exp_vez);
            check("g2_fim", fim, (game2[i].exp_state == 5) ? 1 : 0);
        end
        step();
        check("g2_fim_holds", db_estado, 5);

        // Game 3: reset during AVALIA discards everything
        iniciar = 1'b1;
        step();
        iniciar = 1'b0;
        goto_espera();
        do_move(1'b0, 1'b1, 1'b0);
        check("g3_avalia", db_estado, 3);
        reset = 1'b0;
        step();
        reset = 1'b1;
        check("g3_rst_state", db_estado, 0);
        check("g3_rst_pontos", pontos, 0);
        check("g3_rst_vez", vez, 0);
        check("g3_rst_tempo", tempo, 0);
        check("g3_rst_row", linhaEsperada, 0);
        check("g3_rst_col", colunaEsperada, 0);
        check("g3_rst_acertou", acertou, 0);
        check("g3_rst_errou", errou, 0);
        check("g3_rst_fim", fim, 0);
        iniciar = 1'b1;
        step();
        iniciar = 1'b0;
        goto_espera();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
